chan_player: RTL and testbench

- AXI4-Lite peripheral on the distributor's spare slot (periph5, downstream of axi4lite_dist).
- The CPU writes 4-channel signed 16-bit sample frames into a FIFO.
- A programmable sample-rate divider pops one frame per period and drives channel_a..d plus a one-cycle sample strobe.
- Underflow and low-water conditions drive a level interrupt into a spare irq_ctrl input.

---
 rtl/chan_player.sv | 176 +++++++++++++++++
 tb/tb_chan_player.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_player.sv
// Four-channel sample player: AXI4-Lite slave that queues 16-bit frames and
// plays one frame per programmable sample period, with underflow/low-water irq.
module chan_player #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DIV_DEFAULT = 16'd1561
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_awvalid_i,
  input  logic [31:0]        cfg_awaddr_i,
  input  logic               cfg_wvalid_i,
  input  logic [31:0]        cfg_wdata_i,
  input  logic [3:0]         cfg_wstrb_i,
  input  logic               cfg_bready_i,
  input  logic               cfg_arvalid_i,
  input  logic [31:0]        cfg_araddr_i,
  input  logic               cfg_rready_i,
  output logic               cfg_awready_o,
  output logic               cfg_wready_o,
  output logic               cfg_bvalid_o,
  output logic [1:0]         cfg_bresp_o,
  output logic               cfg_arready_o,
  output logic               cfg_rvalid_o,
  output logic [31:0]        cfg_rdata_o,
  output logic [1:0]         cfg_rresp_o,
  output logic signed [15:0] channel_a,
  output logic signed [15:0] channel_b,
  output logic signed [15:0] channel_c,
  output logic signed [15:0] channel_d,
  output logic               sample_stb_o,
  output logic               intr_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  logic            bvalid_q, rvalid_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            en_q, uie_q, lie_q;
  logic [15:0]     div_q, cnt_q;
  logic [31:0]     stage_q;
  logic [7:0]      lw_q;
  logic            uf_q, ov_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic            stb_q, intr_q;
  logic [15:0]     ch_a_q, ch_b_q, ch_c_q, ch_d_q;

  logic            wr_fire, rd_fire;
  logic            wr_ctrl, wr_status, wr_div, wr_ab, wr_cd, wr_lw;
  logic            flush, tick, pop, push;
  logic [PW-1:0]   level;
  logic [31:0]     level_ext;
  logic            empty, full;
  logic            unused_bits;

  assign wr_fire   = cfg_awvalid_i & cfg_wvalid_i & ~bvalid_q;
  assign rd_fire   = cfg_arvalid_i & ~rvalid_q;
  assign wr_ctrl   = wr_fire && (cfg_awaddr_i[7:0] == 8'h00);
  assign wr_status = wr_fire && (cfg_awaddr_i[7:0] == 8'h04);
  assign wr_div    = wr_fire && (cfg_awaddr_i[7:0] == 8'h08);
  assign wr_ab     = wr_fire && (cfg_awaddr_i[7:0] == 8'h0C);
  assign wr_cd     = wr_fire && (cfg_awaddr_i[7:0] == 8'h10);
  assign wr_lw     = wr_fire && (cfg_awaddr_i[7:0] == 8'h14);

  assign level     = wr_ptr_q - rd_ptr_q;
  assign level_ext = 32'(level);
  assign empty     = (level == '0);
  assign full      = (level == DEPTH_P);

  // Flush pre-empts any tick in the same cycle so the reloaded period starts clean.
  assign flush = wr_ctrl & cfg_wdata_i[1];
  assign tick  = en_q && (cnt_q == '0) && !flush;
  assign pop   = tick & ~empty;
  assign push  = wr_cd & ~full & ~flush;

  assign unused_bits = ^{cfg_awaddr_i[31:8], cfg_araddr_i[31:8], cfg_wstrb_i};

  always_comb begin
    rdata_d = '0;
    case (cfg_araddr_i[7:0])
      8'h00:   rdata_d = {28'd0, lie_q, uie_q, 1'b0, en_q};
      8'h04:   rdata_d = {14'd0, ov_q, uf_q, 6'd0, full, empty, level_ext[7:0]};
      8'h08:   rdata_d = {16'd0, div_q};
      8'h0C:   rdata_d = stage_q;
      8'h14:   rdata_d = {24'd0, lw_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cfg_wdata_i, stage_q};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      uie_q    <= 1'b0;
      lie_q    <= 1'b0;
      div_q    <= DIV_DEFAULT;
      cnt_q    <= DIV_DEFAULT;
      stage_q  <= '0;
      lw_q     <= '0;
      uf_q     <= 1'b0;
      ov_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stb_q    <= 1'b0;
      intr_q   <= 1'b0;
      ch_a_q   <= '0;
      ch_b_q   <= '0;
      ch_c_q   <= '0;
      ch_d_q   <= '0;
    end else begin
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (cfg_bready_i) bvalid_q <= 1'b0;

      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (cfg_rready_i) begin
        rvalid_q <= 1'b0;
      end

      if (wr_ctrl) begin
        en_q  <= cfg_wdata_i[0];
        uie_q <= cfg_wdata_i[2];
        lie_q <= cfg_wdata_i[3];
      end
      if (wr_div) div_q   <= cfg_wdata_i[15:0];
      if (wr_ab)  stage_q <= cfg_wdata_i;
      if (wr_lw)  lw_q    <= cfg_wdata_i[7:0];

      // A new underflow in the same cycle as its W1C clear must survive.
      uf_q <= (uf_q & ~(wr_status & cfg_wdata_i[16])) | (tick & empty);
      ov_q <= (ov_q & ~(wr_status & cfg_wdata_i[17])) | (wr_cd & full);

      if (flush)             cnt_q <= div_q;
      else if (wr_div)       cnt_q <= cfg_wdata_i[15:0];
      else if (!en_q)        cnt_q <= div_q;
      else if (cnt_q == '0)  cnt_q <= div_q;
      else                   cnt_q <= cnt_q - 16'd1;

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      stb_q <= tick;
      if (pop) begin
        {ch_d_q, ch_c_q, ch_b_q, ch_a_q} <= mem_q[rd_ptr_q[AW-1:0]];
      end

      intr_q <= (uf_q & uie_q) | (lie_q & en_q & (level_ext <= {24'd0, lw_q}));
    end
  end

  assign cfg_awready_o = wr_fire;
  assign cfg_wready_o  = wr_fire;
  assign cfg_bvalid_o  = bvalid_q;
  assign cfg_bresp_o   = '0;
  assign cfg_arready_o = ~rvalid_q;
  assign cfg_rvalid_o  = rvalid_q;
  assign cfg_rdata_o   = rdata_q;
  assign cfg_rresp_o   = '0;
  assign channel_a     = ch_a_q;
  assign channel_b     = ch_b_q;
  assign channel_c     = ch_c_q;
  assign channel_d     = ch_d_q;
  assign sample_stb_o  = stb_q;
  assign intr_o        = intr_q;

endmodule

// File: tb/tb_chan_player.sv
// Bench for chan_player: random frames and periods against a queue-based
// model of the player, plus directed handshake, overflow, irq and reset cases.
module tb_chan_player;

  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_DIV = 32'h08;
  localparam logic [31:0] A_AB = 32'h0C, A_CD = 32'h10, A_LW = 32'h14;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0] wstrb = 4'hF;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic signed [15:0] channel_a, channel_b, channel_c, channel_d;
  logic sample_stb_o, intr_o;

  chan_player #(.FIFO_DEPTH(16), .DIV_DEFAULT(16'd1561)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_awvalid_i(awvalid), .cfg_awaddr_i(awaddr), .cfg_wvalid_i(wvalid),
    .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb), .cfg_bready_i(bready),
    .cfg_arvalid_i(arvalid), .cfg_araddr_i(araddr), .cfg_rready_i(rready),
    .cfg_awready_o(awready), .cfg_wready_o(wready), .cfg_bvalid_o(bvalid),
    .cfg_bresp_o(bresp), .cfg_arready_o(arready), .cfg_rvalid_o(rvalid),
    .cfg_rdata_o(rdata), .cfg_rresp_o(rresp),
    .channel_a(channel_a), .channel_b(channel_b), .channel_c(channel_c),
    .channel_d(channel_d), .sample_stb_o(sample_stb_o), .intr_o(intr_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, last_acc_cyc = 0, last_ref = 0, exp_period = 1, stb_cnt = 0;
  bit period_on = 0;

  // Model state: queued frames {d,c,b,a}, sticky flags, shadow registers.
  logic [63:0] model_q[$];
  logic [63:0] exp_ch = '0;
  logic uf_m = 0, ov_m = 0;
  logic [15:0] div_m = 16'd1561;
  logic [3:0] ctrl_m = '0;
  logic [31:0] stage_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int l = model_q.size();
    return {14'd0, ov_m, uf_m, 6'd0, l == 16, l == 0, 8'(l)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_i) begin
      if (sample_stb_o) begin
        stb_cnt++;
        if (period_on) begin
          check("period", 64'(cyc - last_ref), 64'(exp_period));
          last_ref = cyc;
        end
        if (model_q.size() > 0) exp_ch = model_q.pop_front();
        else uf_m = 1'b1;
      end
      check("chan", {channel_d, channel_c, channel_b, channel_a}, exp_ch);
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1; bready = 1;
    #1;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) check("wr_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    last_acc_cyc = cyc;
    case (a[7:0])
      8'h00: begin ctrl_m = d[3:0] & 4'hD; if (d[1]) model_q.delete(); end
      8'h04: begin if (d[16]) uf_m = 0; if (d[17]) ov_m = 0; end
      8'h08: div_m = d[15:0];
      8'h0C: stage_m = d;
      8'h10: if (model_q.size() >= 16) ov_m = 1; else model_q.push_back({d, stage_m});
      default: ;
    endcase
    n = 0;
    while (bvalid && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) check("rd_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    arvalid = 0;
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input logic [31:0] ab, input logic [31:0] cd);
    axi_write(A_AB, ab);
    axi_write(A_CD, cd);
  endtask

  task automatic start_play();
    axi_write(A_CTRL, 32'h1);
    exp_period = int'(div_m) + 1;
    last_ref = last_acc_cyc;
    period_on = 1;
  endtask

  task automatic stop_play();
    axi_write(A_CTRL, 32'h0);
    period_on = 0;
  endtask

  initial begin
    logic [31:0] d;
    int n, base, nf, dv;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_chan", {channel_d, channel_c, channel_b, channel_a}, 64'd0);
    check("rst_stb", 64'(sample_stb_o), 64'd0);
    check("rst_intr", 64'(intr_o), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    rst_i = 1;
    axi_read(A_STAT, d); check("rst_status", 64'(d), 64'h100);
    axi_read(A_DIV, d);  check("rst_div", 64'(d), 64'd1561);
    axi_read(A_CTRL, d); check("rst_ctrl", 64'(d), 64'd0);
    axi_read(32'h40, d); check("unmapped", 64'(d), 64'd0);

    // Two known frames at DIV=3, then an underflow tick
    axi_write(A_DIV, 32'd3);
    push_frame({16'd2, 16'd1}, {16'd4, 16'd3});
    push_frame({16'd6, 16'd5}, {16'd8, 16'd7});
    base = stb_cnt;
    start_play();
    n = 0;
    while (stb_cnt < base + 3 && n < 60) begin @(negedge clk); #1; n++; end
    check("t2_ticks", 64'(stb_cnt - base), 64'd3);
    stop_play();
    check("t2_hold", {channel_d, channel_c, channel_b, channel_a},
          {16'd8, 16'd7, 16'd6, 16'd5});
    axi_read(A_STAT, d); check("t2_status", 64'(d), 64'(exp_status()));
    check("t2_uf", 64'(d[16]), 64'd1);

    // Randomized frames, periods and flushes
    for (int r = 0; r < 6; r++) begin
      axi_write(A_STAT, 32'h30000);
      dv = $urandom_range(0, 6);
      nf = $urandom_range(1, 6);
      axi_write(A_DIV, 32'(dv));
      for (int i = 0; i < nf; i++) push_frame($urandom, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        axi_write(A_CTRL, 32'h2);
        axi_read(A_CTRL, d); check("flush_rd0", 64'(d), 64'(ctrl_m));
        for (int i = 0; i < nf; i++) push_frame($urandom, $urandom);
      end
      axi_read(A_AB, d);   check("stage_rd", 64'(d), 64'(stage_m));
      axi_read(A_STAT, d); check("rnd_pre_status", 64'(d), 64'(exp_status()));
      start_play();
      repeat ((nf + 2) * (dv + 1) + 2) @(negedge clk);
      stop_play();
      axi_read(A_STAT, d); check("rnd_post_status", 64'(d), 64'(exp_status()));
      axi_read(A_DIV, d);  check("rnd_div", 64'(d), 64'(div_m));
    end

    // Overflow: 17 frames while disabled, then drain at DIV=0
    axi_write(A_STAT, 32'h30000);
    for (int i = 0; i < 17; i++) push_frame($urandom | 32'h10001, $urandom | 32'h10001);
    axi_read(A_STAT, d); check("ovf_status", 64'(d), 64'h0002_0210);
    check("ovf_model", 64'(d), 64'(exp_status()));
    axi_write(A_DIV, 32'd0);
    base = stb_cnt;
    start_play();
    repeat (20) @(negedge clk);
    stop_play();
    check("ovf_strobes_min", 64'(stb_cnt - base >= 16), 64'd1);
    axi_read(A_STAT, d); check("ovf_drained", 64'(d), 64'h0003_0100);

    // Low-water and underflow interrupt with W1C racing a new underflow
    axi_write(A_STAT, 32'h30000);
    axi_write(A_LW, 32'd2);
    for (int i = 0; i < 4; i++) push_frame($urandom | 32'h10001, $urandom | 32'h10001);
    check("lw_idle_intr", 64'(intr_o), 64'd0);
    axi_write(A_CTRL, 32'h0D);
    exp_period = 1; last_ref = last_acc_cyc; period_on = 1;
    n = 0;
    while (!intr_o && n < 30) begin @(negedge clk); #1; n++; end
    check("lw_intr", 64'(intr_o), 64'd1);
    check("lw_level", 64'(model_q.size() <= 2), 64'd1);
    repeat (8) @(negedge clk);
    axi_write(A_STAT, 32'h10000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("uf_intr_hold", 64'(intr_o), 64'd1);
    end
    axi_read(A_STAT, d); check("uf_reset", 64'(d[16]), 64'd1);
    stop_play();
    repeat (3) @(negedge clk);
    check("intr_off", 64'(intr_o), 64'd0);

    // Handshake back-pressure on both channels
    axi_write(A_STAT, 32'h30000);
    @(negedge clk);
    awaddr = A_LW; wdata = 32'd5; awvalid = 1; wvalid = 1; bready = 0;
    araddr = A_DIV; arvalid = 1; rready = 0;
    #1;
    check("hs_awready", 64'(awready), 64'd1);
    check("hs_wready", 64'(wready), 64'd1);
    check("hs_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    wdata = 32'd6; arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("hs_bvalid", 64'(bvalid), 64'd1);
      check("hs_awblock", 64'(awready), 64'd0);
      check("hs_rvalid", 64'(rvalid), 64'd1);
      check("hs_arblock", 64'(arready), 64'd0);
    end
    check("hs_rdata", 64'(rdata), 64'(div_m));
    check("hs_resp", 64'({bresp, rresp}), 64'd0);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    check("hs_bclear", 64'(bvalid), 64'd0);
    check("hs_rclear", 64'(rvalid), 64'd0);
    check("hs_second_ready", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    check("hs_second_b", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
    axi_read(A_LW, d); check("hs_lw", 64'(d), 64'd6);

    // Asynchronous reset mid-period with frames queued
    axi_write(A_DIV, 32'd20);
    for (int i = 0; i < 3; i++) push_frame($urandom | 32'h10001, $urandom | 32'h10001);
    base = stb_cnt;
    start_play();
    n = 0;
    while (stb_cnt == base && n < 50) begin @(negedge clk); #1; n++; end
    check("rst_pre_strobe", 64'(stb_cnt - base), 64'd1);
    repeat (5) @(negedge clk);
    #3;
    rst_i = 0;
    model_q.delete(); exp_ch = '0; uf_m = 0; ov_m = 0; div_m = 16'd1561;
    ctrl_m = '0; stage_m = '0; period_on = 0;
    #1;
    check("arst_chan", {channel_d, channel_c, channel_b, channel_a}, 64'd0);
    check("arst_stb", 64'(sample_stb_o), 64'd0);
    check("arst_intr", 64'(intr_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1;
    axi_read(A_STAT, d); check("arst_status", 64'(d), 64'h100);
    axi_read(A_DIV, d);  check("arst_div", 64'(d), 64'd1561);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
